// File: rtl/if_pad_ring.sv
// if_pad_ring: circular pixel ring that replays overlapping windows (len pixels, advancing by stride).
// Latency: a pixel written at edge E can be presented on o_opix_* after edge E+1 (registered output).
// Backpressure: o_ipix_ready drops when the ring is full; i_opix_ready=0 or i_stall holds the output register.
// Ports:
//   i_clk, i_rstn            clock, async active-low reset
//   i_start, i_flush         begin a row (IDLE only) / synchronous abort to IDLE
//   i_stall                  freeze the read side (held pixel may still be consumed)
//   i_cfg_len/stride/nwin    window length, window advance, windows per row (latched at i_start)
//   i_ipix_* / o_ipix_ready  write handshake
//   o_opix_* / i_opix_ready  read handshake
//   o_cnt, o_busy, o_done    occupancy, not-IDLE, end-of-row pulse
module if_pad_ring #(
  parameter int DWd   = 16,
  parameter int Depth = 12,
  parameter int CfgWd = 4,
  parameter int WinWd = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic                       i_start,
  input  logic                       i_flush,
  input  logic                       i_stall,
  input  logic [CfgWd-1:0]           i_cfg_len,
  input  logic [CfgWd-1:0]           i_cfg_stride,
  input  logic [WinWd-1:0]           i_cfg_nwin,
  input  logic [DWd-1:0]             i_ipix_data,
  input  logic                       i_ipix_valid,
  output logic                       o_ipix_ready,
  output logic [DWd-1:0]             o_opix_data,
  output logic                       o_opix_valid,
  input  logic                       i_opix_ready,
  output logic [$clog2(Depth+1)-1:0] o_cnt,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int PW = $clog2(Depth);
  localparam int CW = $clog2(Depth + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state_q, state_d;

  logic [DWd-1:0]   mem_q [Depth];
  logic [PW-1:0]    wptr_q, wptr_d, base_q, base_d, roff_q, roff_d;
  logic [CW-1:0]    cnt_q, cnt_d, len_q, len_d, stride_q, stride_d;
  logic [WinWd-1:0] win_q, win_d, nwin_q, nwin_d;
  logic [DWd-1:0]   opix_data_q, opix_data_d;
  logic             opix_valid_q, opix_valid_d;
  // Marks that the held output pixel is the last of its window.
  logic             last_q, last_d;

  // Config clamping, done in 32-bit so any CfgWd compares cleanly against Depth.
  logic [31:0]      len_raw, str_raw, len_c, str_c;
  logic [WinWd-1:0] nwin_c;

  always_comb begin
    len_raw = 32'(i_cfg_len);
    str_raw = 32'(i_cfg_stride);
    if (len_raw == 32'd0)             len_c = 32'd1;
    else if (len_raw > 32'(Depth))    len_c = 32'(Depth);
    else                              len_c = len_raw;
    if (str_raw == 32'd0)             str_c = 32'd1;
    else if (str_raw > len_c)         str_c = len_c;
    else                              str_c = str_raw;
    nwin_c = (i_cfg_nwin == '0) ? WinWd'(1) : i_cfg_nwin;
  end

  logic          fire_w, fire_r, win_end, last_win, avail, load, at_last;
  logic [PW:0]   base_sum, rd_sum;
  logic [PW-1:0] base_nxt, eff_base, rd_addr, wptr_nxt, roff_nxt;
  logic [CW-1:0] eff_cnt;

  // When the last pixel of a window is consumed in the same cycle that the
  // next pixel loads, the load must already see the advanced base and the
  // reduced count, otherwise a full bubble is needed between windows.
  always_comb begin
    fire_w   = i_ipix_valid & o_ipix_ready;
    fire_r   = opix_valid_q & i_opix_ready;
    win_end  = fire_r & last_q;
    last_win = win_end & ((win_q + WinWd'(1)) == nwin_q);

    base_sum = {1'b0, base_q} + (PW+1)'(stride_q);
    base_nxt = (base_sum >= (PW+1)'(Depth)) ? PW'(base_sum - (PW+1)'(Depth)) : PW'(base_sum);
    eff_base = win_end ? base_nxt : base_q;
    eff_cnt  = win_end ? (cnt_q - stride_q) : cnt_q;

    rd_sum   = {1'b0, eff_base} + {1'b0, roff_q};
    rd_addr  = (rd_sum >= (PW+1)'(Depth)) ? PW'(rd_sum - (PW+1)'(Depth)) : PW'(rd_sum);

    avail    = eff_cnt > CW'(roff_q);
    at_last  = CW'(roff_q) == (len_q - CW'(1));
    roff_nxt = at_last ? '0 : (roff_q + PW'(1));
    wptr_nxt = (wptr_q == PW'(Depth - 1)) ? '0 : (wptr_q + PW'(1));

    load = (state_q == S_RUN) & ~i_stall & ~i_flush & avail &
           (~opix_valid_q | i_opix_ready) & ~last_win;
  end

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_start)  state_d = S_RUN;
      S_RUN:   if (last_win) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (i_flush) state_d = S_IDLE;
  end

  // FSM: outputs
  always_comb begin
    o_busy       = (state_q != S_IDLE);
    o_done       = (state_q == S_DONE);
    o_ipix_ready = (state_q == S_RUN) && (cnt_q < CW'(Depth));
  end

  // Datapath next state
  always_comb begin
    wptr_d       = wptr_q;
    base_d       = base_q;
    roff_d       = roff_q;
    cnt_d        = cnt_q;
    win_d        = win_q;
    len_d        = len_q;
    stride_d     = stride_q;
    nwin_d       = nwin_q;
    opix_data_d  = opix_data_q;
    opix_valid_d = opix_valid_q;
    last_d       = last_q;

    if (i_flush || state_q == S_DONE) begin
      wptr_d       = '0;
      base_d       = '0;
      roff_d       = '0;
      cnt_d        = '0;
      win_d        = '0;
      opix_valid_d = 1'b0;
      last_d       = 1'b0;
    end else if (state_q == S_IDLE) begin
      if (i_start) begin
        len_d    = CW'(len_c);
        stride_d = CW'(str_c);
        nwin_d   = nwin_c;
        wptr_d   = '0;
        base_d   = '0;
        roff_d   = '0;
        cnt_d    = '0;
        win_d    = '0;
      end
    end else begin
      if (fire_w) wptr_d = wptr_nxt;
      if (fire_w)  cnt_d = cnt_d + CW'(1);
      if (win_end) begin
        cnt_d  = cnt_d - stride_q;
        base_d = base_nxt;
        win_d  = win_q + WinWd'(1);
      end
      if (load) begin
        opix_data_d  = mem_q[rd_addr];
        opix_valid_d = 1'b1;
        last_d       = at_last;
        roff_d       = roff_nxt;
      end else if (fire_r) begin
        opix_valid_d = 1'b0;
        last_d       = 1'b0;
      end
      // Row complete: leave DONE with an empty ring.
      if (last_win) begin
        wptr_d = '0;
        base_d = '0;
        roff_d = '0;
        cnt_d  = '0;
        win_d  = '0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wptr_q       <= '0;
      base_q       <= '0;
      roff_q       <= '0;
      cnt_q        <= '0;
      win_q        <= '0;
      len_q        <= CW'(1);
      stride_q     <= CW'(1);
      nwin_q       <= WinWd'(1);
      opix_data_q  <= '0;
      opix_valid_q <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      base_q       <= base_d;
      roff_q       <= roff_d;
      cnt_q        <= cnt_d;
      win_q        <= win_d;
      len_q        <= len_d;
      stride_q     <= stride_d;
      nwin_q       <= nwin_d;
      opix_data_q  <= opix_data_d;
      opix_valid_q <= opix_valid_d;
      last_q       <= last_d;
    end
  end

  // Ring storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (fire_w) mem_q[wptr_q] <= i_ipix_data;
  end

  assign o_opix_data  = opix_data_q;
  assign o_opix_valid = opix_valid_q;
  assign o_cnt        = cnt_q;

endmodule

// File: doc/if_pad_ring.md
IF_PAD_RING -- requirements
Module: if_pad_ring

Interface
REQ-001 Parameter DWd, default 16: pixel data width in bits.
REQ-002 Parameter Depth, default 12: ring entries; any value 2..64, power of two not required.
REQ-003 Parameter CfgWd, default 4: width of i_cfg_len and i_cfg_stride.
REQ-004 Parameter WinWd, default 8: width of i_cfg_nwin.
REQ-005 i_clk  in  1  clock; all state changes on the rising edge.
REQ-006 i_rstn  in  1  reset, asynchronous, active-low.
REQ-007 i_start  in  1  IDLE only: latch config and begin a row.
REQ-008 i_flush  in  1  synchronous abort to IDLE from any state.
REQ-009 i_stall  in  1  freezes the read side only.
REQ-010 i_cfg_len  in  CfgWd  window length in pixels.
REQ-011 i_cfg_stride  in  CfgWd  pixels released per window advance.
REQ-012 i_cfg_nwin  in  WinWd  windows per row.
REQ-013 i_ipix_data  in  DWd; i_ipix_valid  in  1; o_ipix_ready  out  1: write handshake.
REQ-014 o_opix_data  out  DWd; o_opix_valid  out  1; i_opix_ready  in  1: read handshake.
REQ-015 o_cnt  out  clog2(Depth+1)  occupied entries.
REQ-016 o_busy  out  1  high when state is not IDLE.
REQ-017 o_done  out  1  one-cycle pulse at end of row.

Function
REQ-018 State machine SHALL have states IDLE, RUN, DONE.
REQ-019 IDLE with i_start: latch cfg, clear wptr, base, roff, win and cnt; next state RUN.
REQ-020 Config clamping: len=0 -> 1; len>Depth -> Depth; stride=0 -> 1; stride>len -> len; nwin=0 -> 1.
REQ-021 Write fire = i_ipix_valid & o_ipix_ready; o_ipix_ready = (state==RUN) & (cnt<Depth).
REQ-022 Write fire stores data at wptr; wptr advances by 1, wrapping Depth-1 -> 0.
REQ-023 Read address = (base+roff) mod Depth.
REQ-024 Pixel available when cnt > roff, counting only pixels written before the current cycle.
REQ-025 Output register loads when state==RUN, !i_stall, pixel available, and (!o_opix_valid | i_opix_ready).
REQ-026 On load: roff increments; after the last pixel of a window (roff==len-1), roff returns to 0.
REQ-027 Output register holds data and valid until read fire = o_opix_valid & i_opix_ready.
REQ-028 Minimum latency: write fire at edge E -> o_opix_valid high after edge E+1.
REQ-029 Window end = read fire of the last pixel of a window.
REQ-030 On window end: base += stride (mod Depth), cnt -= stride, win += 1.
REQ-031 Same-cycle write fire and window end: cnt_next = cnt + 1 - stride.
REQ-032 When win reaches nwin: state DONE; o_done=1 for that one cycle; cnt, pointers and o_opix_valid cleared; next state IDLE.
REQ-033 i_stall: o_opix_valid/o_opix_data hold and roff is frozen; writes and read fire of the held pixel remain allowed.
REQ-034 i_flush: state IDLE next cycle; o_opix_valid, o_ipix_ready, cnt, pointers cleared; stored data discarded; i_flush has priority over i_start and all fires.
REQ-035 i_start outside IDLE SHALL be ignored.
REQ-036 Each stored pixel SHALL be re-read once per window it falls in; no pixel is overwritten before release (guaranteed by REQ-021).

Reset
REQ-037 On i_rstn low, asynchronously: state IDLE; o_opix_valid=0, o_ipix_ready=0, o_done=0, o_busy=0, o_cnt=0, o_opix_data=0; all pointers 0.
REQ-038 Reset deassertion mid-row SHALL NOT resume the row; i_start is required.

Verification
REQ-039 len=3, stride=1, nwin=4, write 1..6 back-to-back, out always ready -> output 1,2,3,2,3,4,3,4,5,4,5,6; o_done one cycle after the final 6 fires; o_cnt=0 afterwards.
REQ-040 Depth=12, len=12, stride=12, no read ready -> o_cnt reaches 12, then o_ipix_ready=0; enabling reads restores ready the cycle after the 12th read fire.
REQ-041 Wrap: len=5, stride=5, nwin=4, 20 pixels -> output in order, wptr/base wrap correctly through 11->0.
REQ-042 Stall for 5 cycles mid-window with i_opix_ready=0 -> o_opix_data stable, no pixel skipped or duplicated after release.
REQ-043 i_flush during RUN with o_cnt=7 -> next cycle o_busy=0, o_cnt=0, o_opix_valid=0; a new i_start then gives correct output from the first pixel.
REQ-044 Config len=0, stride=9, Depth=12 -> behaves as len=1, stride=1.
